clb_config_loader: RTL

- Serial configuration front-end that sits directly upstream of the CLB array.
- Accepts a framed bitstream one bit per handshake and assembles it in a shadow register.
- Verifies a checksum, then atomically commits the per-CLB configuration words: input select (6b), LUT mask (16b), flip-flop (3b) and output select (2b).
- Holds the CLBs in reset until the first valid configuration is active.

---
 rtl/clb_config_loader.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/clb_config_loader.sv
// ----------------------------------------------------------------------------
// clb_config_loader
//   Serial configuration front-end for the CLB array. A framed bitstream
//   (sync word, NUM_CLBS*27 payload bits, 8-bit ones-count checksum) is
//   taken one bit per cfg_valid/cfg_ready handshake into a shadow register.
//   Once the checksum matches, every per-CLB word is committed on one edge.
//   The CLB array is held in reset until the first good commit.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     cfg_data/valid/ready  serial bit stream with handshake
//     cfg_input_words       CLB k at [6k +: 6]
//     cfg_lut_words         CLB k at [16k +: 16]
//     cfg_ff_words          CLB k at [3k +: 3]
//     cfg_out_words         CLB k at [2k +: 2]
//     clb_reset             reset to the CLB array (drops at first commit)
//     cfg_done              a verified configuration is active
//     cfg_error             last frame failed its checksum (sticky to sync)
//
//   Optional build macro CLB_CONFIG_READBACK_EN adds rb_start / rb_data /
//   rb_valid: serial readback of the active configuration in payload layout.
// ----------------------------------------------------------------------------
module clb_config_loader #(
    parameter int         NUM_CLBS  = 4,
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [NUM_CLBS*6-1:0]   cfg_input_words,
    output logic [NUM_CLBS*16-1:0]  cfg_lut_words,
    output logic [NUM_CLBS*3-1:0]   cfg_ff_words,
    output logic [NUM_CLBS*2-1:0]   cfg_out_words,
    output logic                    clb_reset,
    output logic                    cfg_done,
    output logic                    cfg_error
`ifdef CLB_CONFIG_READBACK_EN
    ,
    input  logic                    rb_start,
    output logic                    rb_data,
    output logic                    rb_valid
`endif
);

    localparam int PW = NUM_CLBS * 27;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        LOAD   = 3'd1,
        CSUM   = 3'd2,
        CHECK  = 3'd3,
        COMMIT = 3'd4,
        RB     = 3'd5
    } state_e;

    state_e                 state_q,  state_d;
    logic [7:0]             win_q,    win_d;
    logic [PW-1:0]          shadow_q, shadow_d;
    logic [7:0]             ones_q,   ones_d;
    logic [CW-1:0]          cnt_q,    cnt_d;
    logic [7:0]             csum_q,   csum_d;
    logic                   ok_q,     ok_d;
    logic [NUM_CLBS*6-1:0]  in_q,     in_d;
    logic [NUM_CLBS*16-1:0] lut_q,    lut_d;
    logic [NUM_CLBS*3-1:0]  ff_q,     ff_d;
    logic [NUM_CLBS*2-1:0]  out_q,    out_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;
    logic                   clbrst_q, clbrst_d;
    logic                   ready_q,  ready_d;

    logic                   xfer;
    logic [7:0]             win_shift;
    logic                   rb_go;

    assign xfer      = cfg_valid && ready_q;
    assign win_shift = {win_q[6:0], cfg_data};

`ifdef CLB_CONFIG_READBACK_EN
    logic [PW-1:0] rb_shift_q, rb_shift_d;
    logic          rb_valid_q, rb_valid_d;
    logic [PW-1:0] active_cfg;

    // Active words repacked into the same layout the payload arrived in.
    always_comb begin
        active_cfg = '0;
        for (int k = 0; k < NUM_CLBS; k++) begin
            active_cfg[27*k +: 27] = {in_q[6*k +: 6], lut_q[16*k +: 16],
                                      ff_q[3*k +: 3], out_q[2*k +: 2]};
        end
    end

    assign rb_go    = rb_start && done_q;
    assign rb_data  = rb_shift_q[PW-1];
    assign rb_valid = rb_valid_q;
`else
    assign rb_go = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        shadow_d = shadow_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        ok_d     = ok_q;
        in_d     = in_q;
        lut_d    = lut_q;
        ff_d     = ff_q;
        out_d    = out_q;
        done_d   = done_q;
        err_d    = err_q;
        clbrst_d = clbrst_q;
`ifdef CLB_CONFIG_READBACK_EN
        rb_shift_d = rb_shift_q;
        rb_valid_d = rb_valid_q;
`endif

        case (state_q)
            HUNT: begin
                if (xfer) win_d = win_shift;
                // A readback request wins over sync detection; a bit accepted
                // in the same cycle still enters the window.
                if (rb_go) begin
                    state_d = RB;
                    cnt_d   = '0;
`ifdef CLB_CONFIG_READBACK_EN
                    rb_shift_d = active_cfg;
                    rb_valid_d = 1'b1;
`endif
                end else if (xfer && win_shift == SYNC_WORD) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    ones_d  = '0;
                    err_d   = 1'b0;
                    // Clear so stale frame bits cannot fake a later sync.
                    win_d   = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    shadow_d = {shadow_q[PW-2:0], cfg_data};
                    ones_d   = ones_q + {7'd0, cfg_data};
                    if (cnt_q == CW'(PW - 1)) begin
                        state_d = CSUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    csum_d = {csum_q[6:0], cfg_data};
                    if (cnt_q == CW'(7)) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                // Compare is registered; the result is applied one edge later
                // so outputs move two edges after the last checksum bit.
                ok_d    = (csum_q == ones_q);
                state_d = COMMIT;
            end
            COMMIT: begin
                if (ok_q) begin
                    for (int k = 0; k < NUM_CLBS; k++) begin
                        in_d[6*k +: 6]   = shadow_q[27*k+21 +: 6];
                        lut_d[16*k +: 16] = shadow_q[27*k+5 +: 16];
                        ff_d[3*k +: 3]   = shadow_q[27*k+2 +: 3];
                        out_d[2*k +: 2]  = shadow_q[27*k +: 2];
                    end
                    done_d   = 1'b1;
                    clbrst_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = HUNT;
            end
`ifdef CLB_CONFIG_READBACK_EN
            RB: begin
                rb_shift_d = {rb_shift_q[PW-2:0], 1'b0};
                if (cnt_q == CW'(PW - 1)) begin
                    rb_valid_d = 1'b0;
                    state_d    = HUNT;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = HUNT;
        endcase

        ready_d = (state_d == HUNT) || (state_d == LOAD) || (state_d == CSUM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HUNT;
            win_q    <= '0;
            shadow_q <= '0;
            ones_q   <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            ok_q     <= 1'b0;
            in_q     <= '0;
            lut_q    <= '0;
            ff_q     <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clbrst_q <= 1'b1;
            ready_q  <= 1'b1;
`ifdef CLB_CONFIG_READBACK_EN
            rb_shift_q <= '0;
            rb_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            shadow_q <= shadow_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            ok_q     <= ok_d;
            in_q     <= in_d;
            lut_q    <= lut_d;
            ff_q     <= ff_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clbrst_q <= clbrst_d;
            ready_q  <= ready_d;
`ifdef CLB_CONFIG_READBACK_EN
            rb_shift_q <= rb_shift_d;
            rb_valid_q <= rb_valid_d;
`endif
        end
    end

    assign cfg_ready       = ready_q;
    assign cfg_input_words = in_q;
    assign cfg_lut_words   = lut_q;
    assign cfg_ff_words    = ff_q;
    assign cfg_out_words   = out_q;
    assign clb_reset       = clbrst_q;
    assign cfg_done        = done_q;
    assign cfg_error       = err_q;

endmodule
